score_tally: RTL and testbench
==============================

# score_tally

Accumulates per-hit judgements from the red/other lane judge stages into the running game score, combo and max-combo, all in BCD for direct display on the LED matrix / seven-segment path. Sits directly downstream of the button judge (consumes its 2-bit score code) and upstream of the display driver. A small FSM gates accumulation to an active game window.

## Interface
Parameters:
- PTS_PERFECT, 3, points for code 2'b11
- PTS_LATE, 1, points for code 2'b10
- PTS_EARLY, 1, points for code 2'b01
- COMBO_BONUS_TH, 10, combo value (binary) at or above which a perfect earns +1 bonus point

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- game_start  in  1  one-cycle pulse; clears tallies, enters PLAY
- game_end  in  1  one-cycle pulse; freezes tallies, enters DONE
- judge_valid  in  1  one-cycle pulse, asserted the cycle the judge's score code is valid
- judge_code  in  2  11 perfect, 10 late, 01 early, 00 none
- note_miss  in  1  one-cycle pulse: a note left the hit window unpressed
- score_bcd  out  16  4-digit BCD total, saturates at 9999
- combo_bcd  out  8  2-digit BCD current combo, saturates at 99
- max_combo_bcd  out  8  2-digit BCD best combo this game
- hit_flash  out  1  one-cycle pulse when a scoring hit is registered
- playing  out  1  high in PLAY

## Operation
- States: IDLE (after reset), PLAY, DONE.
- IDLE --game_start--> PLAY; PLAY --game_end--> DONE; DONE --game_start--> PLAY; game_start in PLAY restarts (clear, stay PLAY). game_end in IDLE/DONE ignored.
- game_start and game_end same cycle: game_start wins.
- Clear on game_start: score, combo, max_combo <= 0; any event in that cycle is discarded.
- Only in PLAY are events processed; elsewhere judge_valid/note_miss ignored and outputs hold.
- Event = judge_valid with code != 00 ("hit"), or judge_valid with code 00, or note_miss ("break").
- Hit: pts = PTS_x for code; if current combo (binary, before increment) >= COMBO_BONUS_TH and code = 11, pts += 1. score += pts (BCD, saturate 9999). combo += 1 (saturate 99). hit_flash pulses.
- Break: combo <= 0; score unchanged; no hit_flash.
- judge_valid (any code) and note_miss same cycle: judge_valid wins, note_miss dropped.
- max_combo <= combo_next whenever combo_next > max_combo (same cycle as combo update).
- Combo kept internally in binary (7 bits) for threshold compare; combo_bcd/max_combo_bcd converted registered outputs.
- Saturation: score never wraps; once 9999, further hits leave it 9999 but still increment combo and pulse hit_flash.

## Timing
- Reset (rst high at clk edge): state IDLE; score_bcd 16'h0000, combo_bcd 8'h00, max_combo_bcd 8'h00, hit_flash 0, playing 0. rst overrides all inputs.
- Latency: event sampled at edge N -> score_bcd, combo_bcd, max_combo_bcd, hit_flash valid after edge N (one cycle). hit_flash high exactly one cycle.
- playing reflects state register (high the cycle after game_start edge).
- Back-to-back events every cycle supported; no backpressure, no handshake beyond pulses.
- Event coincident with game_end: processed, then DONE.

## Structure
- Shared package (score_pkg): judge-code constants (CODE_NONE/EARLY/LATE/PERFECT), FSM state encodings, BCD_MAX_SCORE 16'h9999.
- Sub-module bcd_add_sat: 4-digit BCD plus 0..9 binary addend, ripple digit-carry, saturating to 9999; combinational, instantiated once.
- Binary-to-2-digit-BCD conversion for combo is small inline logic (value ≤ 99).

## Test plan
- Reset then game_start, three perfects on consecutive cycles -> score_bcd 0009, combo_bcd 03, max 03, three hit_flash pulses.
- 10 perfects then 2 perfects -> first 10 give 30, 11th/12th give 4 each: score 0038, combo 12.
- Combo 5, note_miss -> combo 00, max 05, score unchanged; then judge_valid+note_miss same cycle with code 10 -> score +1, combo 01.
- Preload near max: sequence driving score to 9998, then perfect -> 9999, further hit stays 9999, combo still increments.
- game_end then perfect pulses -> all outputs frozen, playing 0; game_start -> all outputs 0, playing 1.
- rst asserted mid-game with judge_valid high same cycle -> all outputs 0, state IDLE, event ignored.

Source files
------------

// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_pkg
//  Description : Shared constants for the score tally block: judge-code
//                values, FSM state encodings, BCD score ceiling and a small
//                binary-to-2-digit-BCD helper.
//  Revision    : 1.0  initial release
// ============================================================================
package score_pkg;

    // Judge score codes as produced by the button judge
    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_EARLY   = 2'b01;
    localparam logic [1:0] CODE_LATE    = 2'b10;
    localparam logic [1:0] CODE_PERFECT = 2'b11;

    // Game window FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [15:0] BCD_MAX_SCORE = 16'h9999;

    // Binary (0..99) to two BCD digits. Input above 99 never occurs because
    // the combo counter saturates at 99.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'd0;
        for (int t = 1; t < 10; t++) begin
            if (v >= 7'(t * 10)) begin
                tens = 4'(t);
            end
        end
        ones = 4'(v - 7'(int'(tens) * 10));
        return {tens, ones};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add_sat.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add_sat
//  Description : Combinational 4-digit BCD adder with a 0..9 binary addend.
//                Digits ripple a decimal carry; a carry out of the top digit
//                saturates the result to 9999.
//  Ports       : i_bcd    [15:0] current BCD value (valid BCD digits)
//                i_addend [3:0]  binary addend, 0..9
//                o_sum    [15:0] saturated BCD sum
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_add_sat
    import score_pkg::*;
(
    input  logic [15:0] i_bcd,
    input  logic [3:0]  i_addend,
    output logic [15:0] o_sum
);

    always_comb begin
        logic [4:0]  w_digit_sum;
        logic        w_carry;
        logic [15:0] w_raw;
        w_carry     = 1'b0;
        w_raw       = 16'h0000;
        w_digit_sum = 5'd0;
        for (int d = 0; d < 4; d++) begin
            // Only the least significant digit receives the addend; higher
            // digits only see the ripple carry.
            if (d == 0) begin
                w_digit_sum = {1'b0, i_bcd[3:0]} + {1'b0, i_addend};
            end else begin
                w_digit_sum = {1'b0, i_bcd[4*d +: 4]} + {4'd0, w_carry};
            end
            if (w_digit_sum > 5'd9) begin
                w_raw[4*d +: 4] = 4'(w_digit_sum - 5'd10);
                w_carry         = 1'b1;
            end else begin
                w_raw[4*d +: 4] = w_digit_sum[3:0];
                w_carry         = 1'b0;
            end
        end
        o_sum = w_carry ? BCD_MAX_SCORE : w_raw;
    end

endmodule
`default_nettype wire

// File: rtl/score_tally.sv
`default_nettype none
// ============================================================================
//  Module      : score_tally
//  Description : Accumulates judge results into a BCD score, current combo
//                and best combo, gated by an IDLE/PLAY/DONE game window.
//  Ports       : clk, rst                synchronous active-high reset
//                game_start, game_end    one-cycle control pulses
//                judge_valid, judge_code judge result strobe and 2-bit code
//                note_miss               unpressed-note strobe (combo break)
//                score_bcd [15:0]        4-digit BCD score, saturates 9999
//                combo_bcd [7:0]         2-digit BCD combo, saturates 99
//                max_combo_bcd [7:0]     best combo in this game
//                hit_flash               one-cycle pulse per scoring hit
//                playing                 high while in PLAY
//  Revision    : 1.0  initial release
// ============================================================================
module score_tally
    import score_pkg::*;
#(
    parameter int unsigned PTS_PERFECT    = 3,
    parameter int unsigned PTS_LATE       = 1,
    parameter int unsigned PTS_EARLY      = 1,
    parameter int unsigned COMBO_BONUS_TH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start,
    input  logic        game_end,
    input  logic        judge_valid,
    input  logic [1:0]  judge_code,
    input  logic        note_miss,
    output logic [15:0] score_bcd,
    output logic [7:0]  combo_bcd,
    output logic [7:0]  max_combo_bcd,
    output logic        hit_flash,
    output logic        playing
);

    // Perfect plus bonus must stay within the adder's 0..9 addend range.
    localparam logic [3:0] c_pts_perfect = 4'(PTS_PERFECT);
    localparam logic [3:0] c_pts_late    = 4'(PTS_LATE);
    localparam logic [3:0] c_pts_early   = 4'(PTS_EARLY);
    localparam logic [6:0] c_bonus_th    = 7'(COMBO_BONUS_TH);
    localparam logic [6:0] c_combo_max   = 7'd99;

    logic [1:0]  r_state;
    logic [15:0] r_score;
    logic [6:0]  r_combo;
    logic [6:0]  r_max_combo;
    logic [7:0]  r_combo_bcd;
    logic [7:0]  r_max_bcd;
    logic        r_hit_flash;

    logic        w_in_play;
    logic        w_event_ok;
    logic        w_hit;
    logic        w_break;
    logic [3:0]  w_pts;
    logic [15:0] w_score_sum;
    logic [6:0]  w_combo_next;
    logic [6:0]  w_max_next;

    assign w_in_play  = (r_state == ST_PLAY);
    // game_start clears the tallies and discards any event in that cycle.
    assign w_event_ok = w_in_play && !game_start;
    assign w_hit      = w_event_ok && judge_valid && (judge_code != CODE_NONE);
    // judge_valid takes priority over a coincident note_miss.
    assign w_break    = w_event_ok &&
                        ((judge_valid && (judge_code == CODE_NONE)) ||
                         (!judge_valid && note_miss));

    always_comb begin
        w_pts = 4'd0;
        case (judge_code)
            CODE_PERFECT: w_pts = c_pts_perfect +
                                  ((r_combo >= c_bonus_th) ? 4'd1 : 4'd0);
            CODE_LATE:    w_pts = c_pts_late;
            CODE_EARLY:   w_pts = c_pts_early;
            default:      w_pts = 4'd0;
        endcase
    end

    bcd_add_sat u_bcd_add_sat (
        .i_bcd    (r_score),
        .i_addend (w_pts),
        .o_sum    (w_score_sum)
    );

    always_comb begin
        w_combo_next = r_combo;
        if (w_hit) begin
            w_combo_next = (r_combo == c_combo_max) ? c_combo_max : r_combo + 7'd1;
        end else if (w_break) begin
            w_combo_next = 7'd0;
        end
        w_max_next = (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_score     <= 16'h0000;
            r_combo     <= 7'd0;
            r_max_combo <= 7'd0;
            r_combo_bcd <= 8'h00;
            r_max_bcd   <= 8'h00;
            r_hit_flash <= 1'b0;
        end else if (game_start) begin
            r_state     <= ST_PLAY;
            r_score     <= 16'h0000;
            r_combo     <= 7'd0;
            r_max_combo <= 7'd0;
            r_combo_bcd <= 8'h00;
            r_max_bcd   <= 8'h00;
            r_hit_flash <= 1'b0;
        end else begin
            r_hit_flash <= w_hit;
            if (w_in_play) begin
                if (w_hit) begin
                    r_score <= w_score_sum;
                end
                r_combo     <= w_combo_next;
                r_max_combo <= w_max_next;
                r_combo_bcd <= bin_to_bcd2(w_combo_next);
                r_max_bcd   <= bin_to_bcd2(w_max_next);
                // An event coincident with game_end is still counted above.
                if (game_end) begin
                    r_state <= ST_DONE;
                end
            end
        end
    end

    assign score_bcd     = r_score;
    assign combo_bcd     = r_combo_bcd;
    assign max_combo_bcd = r_max_bcd;
    assign hit_flash     = r_hit_flash;
    assign playing       = w_in_play;

endmodule
`default_nettype wire

// File: tb/tb_score_tally.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_tally
//  Description : Self-checking bench for score_tally. A behavioural model
//                tracks score/combo/max as plain integers; a compare process
//                checks every output each cycle, and directed scenarios pin
//                hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_score_tally;

    localparam int P_PERFECT = 3;
    localparam int P_LATE    = 1;
    localparam int P_EARLY   = 1;
    localparam int BONUS_TH  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        game_start = 1'b0;
    logic        game_end = 1'b0;
    logic        judge_valid = 1'b0;
    logic [1:0]  judge_code = 2'b00;
    logic        note_miss = 1'b0;
    logic [15:0] score_bcd;
    logic [7:0]  combo_bcd;
    logic [7:0]  max_combo_bcd;
    logic        hit_flash;
    logic        playing;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_score = 0;
    int m_combo = 0;
    int m_max   = 0;
    bit m_flash = 1'b0;
    bit m_play  = 1'b0;
    bit m_valid = 1'b0;

    score_tally #(
        .PTS_PERFECT    (P_PERFECT),
        .PTS_LATE       (P_LATE),
        .PTS_EARLY      (P_EARLY),
        .COMBO_BONUS_TH (BONUS_TH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_start    (game_start),
        .game_end      (game_end),
        .judge_valid   (judge_valid),
        .judge_code    (judge_code),
        .note_miss     (note_miss),
        .score_bcd     (score_bcd),
        .combo_bcd     (combo_bcd),
        .max_combo_bcd (max_combo_bcd),
        .hit_flash     (hit_flash),
        .playing       (playing)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd4(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules in plain integer arithmetic.
    always @(posedge clk) begin
        int pts;
        if (rst) begin
            m_score = 0; m_combo = 0; m_max = 0; m_flash = 0; m_play = 0;
            m_valid = 1'b1;
        end else if (game_start) begin
            m_score = 0; m_combo = 0; m_max = 0; m_flash = 0; m_play = 1;
        end else begin
            m_flash = 0;
            if (m_play) begin
                if (judge_valid && judge_code != 2'b00) begin
                    pts = (judge_code == 2'b11) ? P_PERFECT :
                          (judge_code == 2'b10) ? P_LATE : P_EARLY;
                    if (judge_code == 2'b11 && m_combo >= BONUS_TH) pts = pts + 1;
                    m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
                    m_combo = (m_combo >= 99) ? 99 : m_combo + 1;
                    m_flash = 1;
                end else if (judge_valid || note_miss) begin
                    m_combo = 0;
                end
                if (m_combo > m_max) m_max = m_combo;
                if (game_end) m_play = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("score",     score_bcd,              to_bcd4(m_score));
            check("combo",     {8'h00, combo_bcd},     {8'h00, to_bcd2(m_combo)});
            check("max_combo", {8'h00, max_combo_bcd}, {8'h00, to_bcd2(m_max)});
            check("hit_flash", {15'd0, hit_flash},     {15'd0, m_flash});
            check("playing",   {15'd0, playing},       {15'd0, m_play});
        end
    end

    // Apply one cycle of inputs, then return at the following negedge.
    task automatic step(input bit gs, input bit ge, input bit jv,
                        input logic [1:0] code, input bit nm);
        game_start  = gs;
        game_end    = ge;
        judge_valid = jv;
        judge_code  = code;
        note_miss   = nm;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 2'b00, 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_score", score_bcd, 16'h0000);
        check("rst_combo", {8'h00, combo_bcd}, 16'h0000);
        check("rst_max",   {8'h00, max_combo_bcd}, 16'h0000);
        check("rst_flash", {15'd0, hit_flash}, 16'h0000);
        check("rst_play",  {15'd0, playing}, 16'h0000);
        rst = 1'b0;
        idle();

        // Three consecutive perfects
        step(1, 0, 0, 2'b00, 0);
        check("start_play", {15'd0, playing}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 2'b11, 0);
            check("flash3", {15'd0, hit_flash}, 16'h0001);
        end
        idle();
        check("p3_score", score_bcd, 16'h0009);
        check("p3_combo", {8'h00, combo_bcd}, 16'h0003);
        check("p3_max",   {8'h00, max_combo_bcd}, 16'h0003);
        check("flash_off", {15'd0, hit_flash}, 16'h0000);

        // Twelve perfects, bonus from the 11th
        step(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 2'b11, 0);
        check("p12_score", score_bcd, 16'h0038);
        check("p12_combo", {8'h00, combo_bcd}, 16'h0012);

        // Combo break and priority of judge_valid over note_miss
        step(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 2'b10, 0);
        step(0, 0, 0, 2'b00, 1);
        check("brk_combo", {8'h00, combo_bcd}, 16'h0000);
        check("brk_max",   {8'h00, max_combo_bcd}, 16'h0005);
        check("brk_score", score_bcd, 16'h0005);
        step(0, 0, 1, 2'b10, 1);
        check("both_score", score_bcd, 16'h0006);
        check("both_combo", {8'h00, combo_bcd}, 16'h0001);

        // game_end freezes; perfects ignored; restart clears
        step(0, 1, 0, 2'b00, 0);
        step(0, 0, 1, 2'b11, 0);
        step(0, 0, 1, 2'b11, 0);
        check("done_score", score_bcd, 16'h0006);
        check("done_combo", {8'h00, combo_bcd}, 16'h0001);
        check("done_play",  {15'd0, playing}, 16'h0000);
        step(1, 0, 1, 2'b11, 0);
        check("restart_score", score_bcd, 16'h0000);
        check("restart_play",  {15'd0, playing}, 16'h0001);

        // Mid-game reset with a coincident hit
        step(0, 0, 1, 2'b11, 0);
        rst = 1'b1;
        step(0, 0, 1, 2'b11, 0);
        rst = 1'b0;
        check("mrst_score", score_bcd, 16'h0000);
        check("mrst_play",  {15'd0, playing}, 16'h0000);
        step(0, 0, 1, 2'b11, 0);
        check("idle_ignore", score_bcd, 16'h0000);

        // Drive score to 9998, then saturate
        step(1, 0, 0, 2'b00, 0);
        while (m_score + 4 <= 9998) step(0, 0, 1, 2'b11, 0);
        while (m_score < 9998) step(0, 0, 1, 2'b01, 0);
        check("near_max", score_bcd, 16'h9998);
        check("combo_sat", {8'h00, combo_bcd}, 16'h0099);
        step(0, 0, 0, 2'b00, 1);
        step(0, 0, 1, 2'b11, 0);
        check("sat_score", score_bcd, 16'h9999);
        step(0, 0, 1, 2'b10, 0);
        check("sat_hold",  score_bcd, 16'h9999);
        check("sat_combo", {8'h00, combo_bcd}, 16'h0002);
        check("sat_flash", {15'd0, hit_flash}, 16'h0001);

        // Randomized traffic checked by the per-cycle model comparison
        step(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            rst = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 2) != 0, c, $urandom_range(0, 3) == 0);
            if (!m_play && $urandom_range(0, 9) == 0) begin
                rst = 1'b0;
                step(1, 0, 0, 2'b00, 0);
            end
        end
        rst = 1'b0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
